// File: rtl/rv_muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package rv_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_div(op_e op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/rv_muldiv_if.sv
// Request/result handshake bundle between the core and the multiply/divide unit.
interface rv_muldiv_if #(
    parameter int WIDTH = 32
);
    import rv_muldiv_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_e              op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/rv_muldiv_fix.sv
// Result sign fix-up and selection, evaluated in the FIX cycle.
module rv_muldiv_fix
    import rv_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e                op_i,
    input  logic               neg_i,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   quo_i,
    input  logic [WIDTH-1:0]   rem_i,
    output logic [WIDTH-1:0]   res_o
);
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // The product is negated at full width so the high half carries the borrow correctly.
    assign prod_s = neg_i ? -prod_i : prod_i;
    assign quo_s  = neg_i ? -quo_i  : quo_i;
    assign rem_s  = neg_i ? -rem_i  : rem_i;

    always_comb begin
        res_o = prod_s[2*WIDTH-1:WIDTH];
        case (op_i)
            OP_MUL:          res_o = prod_s[WIDTH-1:0];
            OP_DIV, OP_DIVU: res_o = quo_s;
            OP_REM, OP_REMU: res_o = rem_s;
            default:         res_o = prod_s[2*WIDTH-1:WIDTH];
        endcase
    end

endmodule

// File: rtl/rv_muldiv_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
module rv_muldiv_iter
    import rv_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    rv_muldiv_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;

    logic               a_neg, b_neg, req_rem, div_zero, div_ovf;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   rem_sh, rem_diff;
    logic [WIDTH-1:0]   fix_res;

    assign a_neg    = is_signed_a(bus.op) && bus.src_a[WIDTH-1];
    assign b_neg    = is_signed_b(bus.op) && bus.src_b[WIDTH-1];
    assign mag_a    = a_neg ? -bus.src_a : bus.src_a;
    assign mag_b    = b_neg ? -bus.src_b : bus.src_b;
    assign req_rem  = bus.op inside {OP_REM, OP_REMU};
    assign div_zero = is_div(bus.op) && (bus.src_b == '0);
    assign div_ovf  = is_div(bus.op) && is_signed_a(bus.op)
                      && (bus.src_a == MIN_NEG) && (bus.src_b == ALL_ONES);

    // acc low half holds the multiplier (shifting out right) or the dividend/quotient (shifting left).
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign rem_sh   = {rem_q, acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {2'b00, opb_q};

    rv_muldiv_fix #(.WIDTH(WIDTH)) u_fix (
        .op_i   (op_q),
        .neg_i  (neg_q),
        .prod_i (acc_q),
        .quo_i  (acc_q[WIDTH-1:0]),
        .rem_i  (rem_q[WIDTH-1:0]),
        .res_o  (fix_res)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        opb_d   = opb_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && !flush) begin
                    op_d  = bus.op;
                    neg_d = req_rem ? a_neg : (a_neg ^ b_neg);
                    cnt_d = CNT_W'(WIDTH);
                    acc_d = {{WIDTH{1'b0}}, is_div(bus.op) ? mag_a : mag_b};
                    opb_d = is_div(bus.op) ? mag_b : mag_a;
                    rem_d = '0;
                    if (div_zero) begin
                        res_d   = req_rem ? bus.src_a : ALL_ONES;
                        state_d = ST_DONE;
                    end else if (div_ovf) begin
                        res_d   = req_rem ? '0 : MIN_NEG;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div(op_q)) begin
                    rem_d = rem_diff[WIDTH+1] ? rem_sh[WIDTH:0] : rem_diff[WIDTH:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~rem_diff[WIDTH+1]};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                res_d   = fix_res;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clock) begin
        op_q  <= op_d;
        neg_q <= neg_d;
        acc_q <= acc_d;
        rem_q <= rem_d;
        opb_q <= opb_d;
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = res_q;

endmodule
